ram_access_ctrl: RTL and testbench
==================================

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning BUSY cycles inserted before each ACCESS (legal range 0..15).
REQ-002 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words stored.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port ramREN  input  1  read request from memory_control.
REQ-006 SHALL have port ramWEN  input  1  write request from memory_control.
REQ-007 SHALL have port ramaddr  input  32 (word_t)  byte address; word index = ramaddr[log2(DEPTH)+1:2].
REQ-008 SHALL have port ramstore  input  32 (word_t)  write data.
REQ-009 SHALL have port ramload  output  32 (word_t)  read data.
REQ-010 SHALL have port ramstate  output  ramstate_t  one of FREE, BUSY, ACCESS, ERROR.

Function
REQ-011 SHALL hold state register st (ramstate_t), down-counter cnt (4 bits), and latched request {lREN, lWEN, laddr}; ramstate = st, registered.
REQ-012 SHALL define "illegal" as: ramREN & ramWEN, or ramaddr[1:0] != 0, or word index >= DEPTH.
REQ-013 FREE: no request -> FREE; illegal -> ERROR; legal request -> BUSY with cnt=LAT and request latched, or -> ACCESS directly if LAT=0.
REQ-014 BUSY: request dropped -> FREE; illegal -> ERROR; request/address differs from latched -> relatch, cnt=LAT, stay BUSY; else cnt==1 -> ACCESS, otherwise cnt decrements.
REQ-015 Latency: request held stable from cycle k yields BUSY in cycles k+1..k+LAT and ACCESS in cycle k+LAT+1.
REQ-016 ACCESS SHALL last exactly one cycle; next state evaluated as from FREE (a held request starts a new transaction, it is not re-granted).
REQ-017 During ACCESS with lREN, ramload SHALL equal mem[laddr index] combinationally; in every other cycle ramload SHALL be 32'h0.
REQ-018 During ACCESS with lWEN, mem[laddr index] SHALL take ramstore at the closing clock edge; a read of the same word in a later ACCESS returns the new value.
REQ-019 Write data SHALL be sampled at the ACCESS edge, not at latch time.
REQ-020 ERROR: request dropped -> FREE; legal request -> BUSY (cnt=LAT) or ACCESS if LAT=0; still illegal -> ERROR; memory SHALL never be written from ERROR.
REQ-021 If the request changes in the ACCESS cycle itself, the access SHALL complete with the latched request; the new request is evaluated per REQ-016.
REQ-022 No memory write SHALL occur outside ACCESS with lWEN.

Reset
REQ-023 While RST=1, st=FREE, cnt=0, lREN=lWEN=0, laddr=0, ramload=0, all DEPTH words=0; takes effect immediately, without waiting for a clock edge.
REQ-024 Reset asserted mid-BUSY or mid-ACCESS SHALL abort the transaction with no write performed; after release, the first rising edge evaluates as FREE.

Structure
REQ-025 ramstate_t and word_t SHALL come from cpu_types_pkg; no new package types.
REQ-026 Storage SHALL be a single sub-module ram_word_array (DEPTH x 32, one async read port, one sync write port, async clear); FSM and counter live in ram_access_ctrl.

Verification
REQ-027 LAT=2, write 0x0000_0040 <- 0xDEADBEEF held: ramstate FREE,BUSY,BUSY,ACCESS; a following read of 0x40 gives ramload=0xDEADBEEF in its ACCESS cycle only.
REQ-028 LAT=0, read 0x10 after reset: ACCESS on the first cycle after sampling, ramload=0x0.
REQ-029 LAT=3, read 0x20, switch to 0x24 on 2nd BUSY cycle: counter restarts, ACCESS appears 4 cycles after the switch, data from 0x24.
REQ-030 ramREN=ramWEN=1, or ramaddr=0x3: ramstate=ERROR next cycle, memory unchanged; dropping both requests -> FREE.
REQ-031 Write 0x80 <- 0x12345678, RST pulsed during 2nd BUSY cycle: ramstate=FREE immediately; a later read of 0x80 returns 0x0.
REQ-032 Read 0x400 with DEPTH=256 (index out of range): ERROR, ramload=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
// Word and RAM handshake state used across memory blocks.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;
endpackage

// File: rtl/ram_access_ctrl_array.sv
// Word storage: DEPTH x 32, async read, sync write.
// The whole array clears asynchronously on reset.
module ram_word_array
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_access_ctrl.sv
// RAM access controller: latency-inserting FSM in front
// of a word array, with request legality checking.
module ram_access_ctrl
  import cpu_types_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 256
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT4 = 4'(LAT);

  ramstate_t     st;
  logic [3:0]    cnt;
  logic          lren;
  logic          lwen;
  word_t         laddr;
  logic          req;
  logic          illegal;
  logic          same;
  logic          we;
  logic [AW-1:0] idx;
  word_t         rdata;

  assign req     = ramREN | ramWEN;
  // Index range uses every address bit, not just the decoded ones.
  assign illegal = (ramREN & ramWEN)
                 | (ramaddr[1:0] != 2'b00)
                 | ({2'b00, ramaddr[31:2]} >= 32'(DEPTH));
  assign same    = (ramREN == lren) && (ramWEN == lwen)
                 && (ramaddr == laddr);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st    <= FREE;
      cnt   <= '0;
      lren  <= 1'b0;
      lwen  <= 1'b0;
      laddr <= '0;
    end else begin
      case (st)
        BUSY: begin
          if (!req) begin
            st <= FREE;
          end else if (illegal) begin
            st <= ERROR;
          end else if (!same) begin
            lren  <= ramREN;
            lwen  <= ramWEN;
            laddr <= ramaddr;
            cnt   <= LAT4;
            st    <= BUSY;
          end else if (cnt == 4'd1) begin
            st <= ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          // FREE, ACCESS and ERROR all start a fresh transaction.
          if (!req) begin
            st <= FREE;
          end else if (illegal) begin
            st <= ERROR;
          end else begin
            lren  <= ramREN;
            lwen  <= ramWEN;
            laddr <= ramaddr;
            cnt   <= LAT4;
            st    <= (LAT == 0) ? ACCESS : BUSY;
          end
        end
      endcase
    end
  end

  assign we       = (st == ACCESS) && lwen;
  assign idx      = laddr[AW+1:2];
  assign ramstate = st;
  assign ramload  = (st == ACCESS && lren) ? rdata : '0;

  ram_word_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (CLK),
    .rst   (RST),
    .we    (we),
    .waddr (idx),
    .raddr (idx),
    .wdata (ramstore),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench: three controllers with LAT 2, 0 and 3,
// per-cycle expectations queued by stimulus, checked by a monitor.
module tb_ram_access_ctrl;
  import cpu_types_pkg::*;

  typedef struct {
    int        d;
    ramstate_t st;
    word_t     ld;
    string     nm;
  } exp_t;

  logic      CLK = 1'b0;
  logic      RST = 1'b1;
  logic [2:0] ren = '0;
  logic [2:0] wen = '0;
  word_t     addr  [3];
  word_t     store [3];
  word_t     ld0, ld1, ld2;
  ramstate_t st0, st1, st2;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ram_access_ctrl #(.LAT(2), .DEPTH(256)) u0 (
    .CLK(CLK), .RST(RST), .ramREN(ren[0]), .ramWEN(wen[0]),
    .ramaddr(addr[0]), .ramstore(store[0]),
    .ramload(ld0), .ramstate(st0)
  );
  ram_access_ctrl #(.LAT(0), .DEPTH(256)) u1 (
    .CLK(CLK), .RST(RST), .ramREN(ren[1]), .ramWEN(wen[1]),
    .ramaddr(addr[1]), .ramstore(store[1]),
    .ramload(ld1), .ramstate(st1)
  );
  ram_access_ctrl #(.LAT(3), .DEPTH(256)) u2 (
    .CLK(CLK), .RST(RST), .ramREN(ren[2]), .ramWEN(wen[2]),
    .ramaddr(addr[2]), .ramstore(store[2]),
    .ramload(ld2), .ramstate(st2)
  );

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t      e;
      ramstate_t as;
      word_t     al;
      e = q.pop_front();
      case (e.d)
        0:       begin as = st0; al = ld0; end
        1:       begin as = st1; al = ld1; end
        default: begin as = st2; al = ld2; end
      endcase
      checks++;
      if (as !== e.st || al !== e.ld) begin
        errors++;
        $display("FAIL %s dut%0d: got state=%s load=%h, want state=%s load=%h",
                 e.nm, e.d, as.name(), al, e.st.name(), e.ld);
      end
    end
  end

  task automatic cyc(input int d, input logic r, input logic w,
                     input word_t a, input word_t s, input logic rs,
                     input ramstate_t es, input word_t el,
                     input string nm);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rs;
    ren = '0;
    wen = '0;
    for (int i = 0; i < 3; i++) begin
      addr[i]  = '0;
      store[i] = '0;
    end
    ren[d]   = r;
    wen[d]   = w;
    addr[d]  = a;
    store[d] = s;
    e = '{d, es, el, nm};
    q.push_back(e);
  endtask

  // Request held for LAT+1 cycles, dropped during ACCESS.
  task automatic xfer(input int d, input logic r, input logic w,
                      input word_t a, input word_t s0, input word_t s1,
                      input int lat, input word_t el, input string nm);
    cyc(d, r, w, a, s0, 1'b0, FREE, '0, nm);
    for (int i = 0; i < lat; i++)
      cyc(d, r, w, a, s0, 1'b0, BUSY, '0, nm);
    cyc(d, 1'b0, 1'b0, '0, s1, 1'b0, ACCESS, el, nm);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      addr[i]  = '0;
      store[i] = '0;
    end
    cyc(0, 0, 0, '0, '0, 1'b1, FREE, '0, "reset");

    // LAT=2 write then read; store changes before the ACCESS edge
    xfer(0, 0, 1, 32'h40, 32'h1111_1111, 32'hDEAD_BEEF, 2, '0, "wr40");
    xfer(0, 1, 0, 32'h40, '0, '0, 2, 32'hDEAD_BEEF, "rd40");
    cyc(0, 0, 0, '0, '0, 0, FREE, '0, "rd40_done");

    // illegal requests
    cyc(0, 1, 1, 32'h40, 32'hFFFF_FFFF, 0, FREE,  '0, "both_req");
    cyc(0, 1, 1, 32'h40, 32'hFFFF_FFFF, 0, ERROR, '0, "both_err");
    cyc(0, 0, 0, '0, '0, 0, ERROR, '0, "both_drop");
    cyc(0, 0, 1, 32'h3, 32'hFFFF_FFFF, 0, FREE,  '0, "misal_req");
    cyc(0, 0, 0, '0, '0, 0, ERROR, '0, "misal_err");
    cyc(0, 1, 0, 32'h400, '0, 0, FREE,  '0, "oor_req");
    cyc(0, 1, 0, 32'h40,  '0, 0, ERROR, '0, "oor_err");
    cyc(0, 1, 0, 32'h40,  '0, 0, BUSY,  '0, "err_busy1");
    cyc(0, 1, 0, 32'h40,  '0, 0, BUSY,  '0, "err_busy2");
    cyc(0, 0, 0, '0, '0, 0, ACCESS, 32'hDEAD_BEEF, "mem_kept");
    cyc(0, 0, 0, '0, '0, 0, FREE,  '0, "mem_kept_done");

    // LAT=0
    cyc(1, 1, 0, 32'h10, '0, 0, FREE,   '0, "l0_rd");
    cyc(1, 0, 0, '0, '0, 0, ACCESS, '0, "l0_acc");
    cyc(1, 0, 1, 32'h10, 32'hCAFE_F00D, 0, FREE, '0, "l0_wr");
    cyc(1, 1, 0, 32'h10, 32'hCAFE_F00D, 0, ACCESS, '0, "l0_wacc");
    cyc(1, 0, 0, '0, '0, 0, ACCESS, 32'hCAFE_F00D, "l0_racc");
    cyc(1, 0, 0, '0, '0, 0, FREE, '0, "l0_done");

    // LAT=3 address switch mid-BUSY
    xfer(2, 0, 1, 32'h20, 32'hAAAA_0020, 32'hAAAA_0020, 3, '0, "w20");
    xfer(2, 0, 1, 32'h24, 32'hBBBB_0024, 32'hBBBB_0024, 3, '0, "w24");
    cyc(2, 1, 0, 32'h20, '0, 0, FREE, '0, "sw_req");
    cyc(2, 1, 0, 32'h20, '0, 0, BUSY, '0, "sw_b1");
    cyc(2, 1, 0, 32'h24, '0, 0, BUSY, '0, "sw_b2");
    cyc(2, 1, 0, 32'h24, '0, 0, BUSY, '0, "sw_b3");
    cyc(2, 1, 0, 32'h24, '0, 0, BUSY, '0, "sw_b4");
    cyc(2, 1, 0, 32'h24, '0, 0, BUSY, '0, "sw_b5");
    cyc(2, 0, 0, '0, '0, 0, ACCESS, 32'hBBBB_0024, "sw_acc");
    cyc(2, 0, 0, '0, '0, 0, FREE, '0, "sw_done");

    // reset during BUSY aborts the write
    cyc(0, 0, 1, 32'h80, 32'h1234_5678, 0, FREE, '0, "rw_req");
    cyc(0, 0, 1, 32'h80, 32'h1234_5678, 0, BUSY, '0, "rw_b1");
    cyc(0, 0, 1, 32'h80, 32'h1234_5678, 1, FREE, '0, "rw_rst");
    cyc(0, 0, 0, '0, '0, 0, FREE, '0, "rw_rel");
    xfer(0, 1, 0, 32'h80, '0, '0, 2, '0, "rd80");
    xfer(1, 1, 0, 32'h10, '0, '0, 0, '0, "rd10_clr");
    cyc(1, 0, 0, '0, '0, 0, FREE, '0, "end");

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
